// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each popped word onto an 8N1 UART line.
// All outputs are registered from the current state, so tx trails the FSM by one cycle.
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_busy,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  tx_active
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic                  r_tx;
    logic                  r_pop;
    logic                  r_active;

    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic [BAUD_W-1:0]     w_baud_cnt_next;
    logic                  w_tx_next;
    logic                  w_pop_next;
    logic                  w_active_next;
    logic                  w_baud_done;
    logic                  w_can_pop;

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_can_pop   = enable && !fifo_empty && !fifo_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_pop      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_tx       <= w_tx_next;
            r_pop      <= w_pop_next;
            r_active   <= w_active_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
        w_tx_next       = 1'b1;
        w_pop_next      = 1'b0;
        w_active_next   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_baud_cnt_next = '0;
                w_bit_idx_next  = '0;
                w_active_next   = w_can_pop;
                // fifo_data is only trusted in this cycle; the frame runs from the copy
                if (w_can_pop) begin
                    w_shift_next = fifo_data;
                    w_pop_next   = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_baud_cnt_next = '0;
                w_state_next    = ST_START;
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    w_shift_next    = r_shift >> 1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    w_state_next    = ST_IDLE;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_shift_next    = '0;
                w_bit_idx_next  = '0;
                w_baud_cnt_next = '0;
                w_active_next   = 1'b0;
            end
        endcase
    end

    assign fifo_pop  = r_pop;
    assign tx        = r_tx;
    assign tx_active = r_active;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes each
// frame off tx and compares it bit by bit against the queue head.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_busy;
    logic          fifo_pop;
    logic          tx;
    logic          tx_active;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pop_count = 0;
    int last_pop_cyc = -1;
    int frames_done = 0;

    logic [7:0] push_q[$];
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         popcyc_q[$];
    int         start_cyc[$];

    fifo_uart_tx #(
        .DATA_WIDTH(DW),
        .CLOCK_FREQ(16),
        .BAUD_RATE (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_busy (fifo_busy),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .tx_active (tx_active)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (pop_count < target && k < budget) begin
            tick(1);
            k++;
        end
        if (pop_count < target) check({name, "_timeout"}, pop_count, target);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            tick(1);
            k++;
        end
        if (frames_done < target) check({name, "_timeout"}, frames_done, target);
    endtask

    // FIFO model and pop monitor: legality is judged on the inputs the DUT saw at the pop edge
    initial begin
        logic       prev_pop, prev_empty, prev_busy, prev_en;
        logic [7:0] d;
        prev_pop = 1'b0; prev_empty = 1'b1; prev_busy = 1'b0; prev_en = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(negedge clock);
            if (fifo_pop) begin
                pop_count++;
                last_pop_cyc = cyc;
                popcyc_q.push_back(cyc);
                check("pop_legal", int'({prev_pop, prev_empty, prev_busy, !prev_en}), 0);
                d = 8'h00;
                if (fq.size() > 0) d = fq.pop_front();
                $display("pop %0d at cycle %0d byte %02h", pop_count, cyc, d);
            end
            while (push_q.size() > 0) fq.push_back(push_q.pop_front());
            fifo_empty = (fq.size() == 0);
            fifo_data  = 8'h00;
            if (fq.size() > 0) fifo_data = fq[0];
            prev_pop   = fifo_pop;
            prev_empty = fifo_empty;
            prev_busy  = fifo_busy;
            prev_en    = enable;
        end
    end

    // Line monitor: a falling tx edge starts a frame checked against the scoreboard head
    initial begin
        logic       prev_tx, expb, aborted;
        logic [7:0] e, rx;
        int         s, p, ok, fn;
        prev_tx = 1'b1;
        fn = 0;
        forever begin
            @(negedge clock);
            if (reset_n && prev_tx && !tx) begin
                s = cyc;
                check("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    p = -100;
                    if (popcyc_q.size() > 0) p = popcyc_q.pop_front();
                    start_cyc.push_back(s);
                    check($sformatf("frame%0d_start_latency", fn), s - p, 2);
                    aborted = 1'b0;
                    rx = '0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
                        ok = 0;
                        for (int k = 0; k < CPB && !aborted; k++) begin
                            if (b > 0 || k > 0) @(negedge clock);
                            if (!reset_n) begin
                                aborted = 1'b1;
                            end else begin
                                if (tx == expb && tx_active == 1'b1) ok++;
                                if (k == 1 && b >= 1 && b <= 8) rx[b-1] = tx;
                            end
                        end
                        if (!aborted) check($sformatf("frame%0d_bit%0d_cycles", fn, b), ok, CPB);
                    end
                    if (aborted) begin
                        $display("frame %0d byte %02h aborted by reset at cycle %0d", fn, e, cyc);
                    end else begin
                        check($sformatf("frame%0d_byte", fn), int'(rx), int'(e));
                        @(negedge clock);
                        if (!fifo_pop) check($sformatf("frame%0d_active_fall", fn), int'(tx_active), 0);
                        frames_done++;
                        $display("frame %0d byte %02h start cycle %0d rx %02h", fn, e, s, rx);
                    end
                    fn++;
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeds limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, base;
        reset_n = 1'b1;
        enable = 1'b1;
        fifo_busy = 1'b0;
        #1 reset_n = 1'b0;

        // Reset held with a byte waiting, then the single A5 frame
        push_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("reset_outputs", int'({tx, fifo_pop, tx_active}), 3'b100);
        end
        reset_n = 1'b1;
        c = cyc;
        check("no_pop_at_release", int'(fifo_pop), 0);
        wait_pops(1, 10, "t2_pop");
        check("t2_pop_cycle", last_pop_cyc, c + 1);
        wait_frames(1, 100, "t2_frame");
        check("t2_single_pop", pop_count, 1);

        // Three bytes back-to-back
        push_q.push_back(8'h00); exp_q.push_back(8'h00);
        push_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        push_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        wait_frames(4, 300, "t3_frames");
        check("t3_pop_count", pop_count, 4);
        check("t3_spacing_1", start_cyc[2] - start_cyc[1], 42);
        check("t3_spacing_2", start_cyc[3] - start_cyc[2], 42);

        // Busy holds off the pop
        fifo_busy = 1'b1;
        push_q.push_back(8'hB7); exp_q.push_back(8'hB7);
        base = pop_count;
        tick(10);
        check("t4_no_pop_while_busy", pop_count, base);
        fifo_busy = 1'b0;
        c = cyc;
        wait_pops(base + 1, 10, "t4_pop");
        check("t4_pop_cycle", last_pop_cyc, c + 1);
        wait_frames(5, 100, "t4_frame");

        // Reset during data bit 3 of 5A
        push_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        base = pop_count;
        wait_pops(base + 1, 10, "t5_pop");
        while (cyc < last_pop_cyc + 2 + 4 * CPB + 1) tick(1);
        check("t5_active_before_reset", int'(tx_active), 1);
        reset_n = 1'b0;
        #1;
        check("t5_reset_outputs", int'({tx, fifo_pop, tx_active}), 3'b100);
        tick(3);
        reset_n = 1'b1;
        base = pop_count;
        tick(60);
        check("t5_no_pop_after_reset", pop_count, base);
        check("t5_frames_unchanged", frames_done, 5);

        // Enable low blocks popping; dropping it mid-frame lets the frame finish
        enable = 1'b0;
        push_q.push_back(8'h11); exp_q.push_back(8'h11);
        push_q.push_back(8'h22);
        base = pop_count;
        tick(50);
        check("t6_no_pop_disabled", pop_count, base);
        enable = 1'b1;
        c = cyc;
        wait_pops(base + 1, 10, "t6_pop");
        check("t6_pop_cycle", last_pop_cyc, c + 1);
        tick(10);
        enable = 1'b0;
        wait_frames(6, 100, "t6_frame");
        tick(60);
        check("t6_single_pop", pop_count, base + 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
